mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  operation request from control unit (div_control), sampled only in IDLE.
REQ-004 SHALL have port div_or_mult  input  1  operation select: 0 = signed multiply, 1 = signed divide; sampled with start.
REQ-005 SHALL have port a  input  32  operand A (multiplicand / dividend), two's complement.
REQ-006 SHALL have port b  input  32  operand B (multiplier / divisor), two's complement.
REQ-007 SHALL have port hi  output  32  HI register: product[63:32] or remainder.
REQ-008 SHALL have port lo  output  32  LO register: product[31:0] or quotient.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-010 SHALL have port done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-011 SHALL have port div_zero  output  1  one-cycle pulse when a divide with b = 0 is requested.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-013 SHALL, in IDLE with start=1, latch a, b, div_or_mult into internal registers and enter RUN with iteration counter = 0.
REQ-014 SHALL ignore start while in RUN or FINISH; latched operands unaffected by input changes after acceptance.
REQ-015 SHALL perform multiply as radix-2 Booth, one step per cycle, 32 steps in RUN, giving the exact signed 64-bit product.
REQ-016 SHALL perform divide as restoring division on operand magnitudes, one quotient bit per cycle, 32 steps in RUN, then sign-correct.
REQ-017 SHALL produce MIPS divide semantics: quotient truncated toward zero, remainder takes the sign of the dividend.
REQ-018 SHALL return lo = 0x80000000, hi = 0x00000000 for 0x80000000 / 0xFFFFFFFF (no exception).
REQ-019 SHALL leave RUN after the 32nd step (counter 31) and enter FINISH; in FINISH write hi/lo, assert done for exactly one cycle, then return to IDLE.
REQ-020 SHALL give fixed latency: start sampled at edge N -> done=1 and new hi/lo visible after edge N+33.
REQ-021 SHALL, for divide with b = 0, skip RUN: go IDLE -> FINISH, assert div_zero and done together for one cycle, leave hi/lo unchanged.
REQ-022 SHALL hold hi/lo stable except at the FINISH write; busy = 1 exactly in RUN.
REQ-023 SHALL accept a new start in the IDLE cycle following FINISH (back-to-back operation period = 34 cycles).

Reset
REQ-024 SHALL, on reset=1 at a rising edge, enter IDLE and clear hi, lo, counter, and latched operands to 0, and drive busy, done, div_zero to 0.
REQ-025 SHALL abort any operation when reset is asserted mid-RUN or in FINISH; no done pulse and no hi/lo update for the aborted operation.
REQ-026 SHALL give reset priority over start in the same cycle.

Structure
REQ-027 SHALL place state encoding (IDLE/RUN/FINISH), op encoding (OP_MULT=0, OP_DIV=1) and ITERATIONS=32 in shared package mult_div_pkg.
REQ-028 SHALL isolate the per-cycle restoring divide step (partial remainder, quotient bit) in sub-module div_step; Booth step stays inline.

Verification
REQ-029 SHALL cover: mult a=7, b=0xFFFFFFFD -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
REQ-030 SHALL cover: mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 SHALL cover: div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: hi=0x11, lo=0x22 preset, div a=5, b=0 -> div_zero=done=1 one cycle after start, hi=0x11, lo=0x22 unchanged, busy never high.
REQ-033 SHALL cover: mult started, start re-pulsed with new operands at cycle 5 -> ignored, original product returned at cycle 33.
REQ-034 SHALL cover: reset asserted at cycle 10 of a divide -> next cycle IDLE, hi=lo=0, busy=0, no done; new start then completes normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings and sizing for the multi-cycle signed multiply/divide unit.
package mult_div_pkg;

    localparam int DATA_W     = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import mult_div_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              quotient_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // rem < divisor <= 2^31, so the 33-bit difference never wraps ambiguously.
    assign shifted      = {rem, dividend_bit};
    assign trial        = shifted - {1'b0, divisor};
    assign quotient_bit = ~trial[DATA_W];
    assign rem_next     = quotient_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, MIPS semantics) into HI/LO.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              div_or_mult,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              op_reg;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] shreg;
    logic              qm1;

    logic [DATA_W:0]   multiplicand;
    logic [DATA_W:0]   booth_sum;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] divisor_mag;
    logic [DATA_W-1:0] rem_next;
    logic              quotient_bit;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              zero_div;

    // acc is one bit wider than the operand so -(-2^31) is representable.
    assign multiplicand = {a_reg[DATA_W-1], a_reg};

    always_comb begin
        booth_sum = acc;
        case ({shreg[0], qm1})
            2'b01:   booth_sum = acc + multiplicand;
            2'b10:   booth_sum = acc - multiplicand;
            default: booth_sum = acc;
        endcase
    end

    assign a_mag       = a[DATA_W-1] ? -a : a;
    assign divisor_mag = b_reg[DATA_W-1] ? -b_reg : b_reg;

    div_step u_div_step (
        .rem          (acc[DATA_W-1:0]),
        .dividend_bit (shreg[DATA_W-1]),
        .divisor      (divisor_mag),
        .rem_next     (rem_next),
        .quotient_bit (quotient_bit)
    );

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quotient  = (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]) ? -shreg : shreg;
    assign remainder = a_reg[DATA_W-1] ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign zero_div  = (op_reg == OP_DIV) && (b_reg == '0);
    assign busy      = (state == RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= OP_MULT;
            acc      <= '0;
            shreg    <= '0;
            qm1      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        op_reg <= div_or_mult;
                        count  <= '0;
                        acc    <= '0;
                        qm1    <= 1'b0;
                        if (div_or_mult == OP_DIV) begin
                            shreg <= a_mag;
                            state <= (b == '0) ? FINISH : RUN;
                        end else begin
                            shreg <= b;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op_reg == OP_MULT) begin
                        // Arithmetic right shift of the combined {acc, shreg, qm1} register.
                        acc   <= {booth_sum[DATA_W], booth_sum[DATA_W:1]};
                        shreg <= {booth_sum[0], shreg[DATA_W-1:1]};
                        qm1   <= shreg[0];
                    end else begin
                        acc   <= {1'b0, rem_next};
                        shreg <= {shreg[DATA_W-2:0], quotient_bit};
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITERATIONS - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= zero_div;
                    if (!zero_div) begin
                        if (op_reg == OP_MULT) begin
                            hi <= acc[DATA_W-1:0];
                            lo <= shreg;
                        end else begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized operations against an arithmetic model.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        div_or_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int          n_checks;
    int          n_fail;
    logic [63:0] exp_q[$];

    mult_div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .div_or_mult (div_or_mult),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: {hi, lo} from plain 64-bit signed arithmetic (SV / and % truncate toward zero).
    function automatic logic [63:0] model(input logic op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 1'b0) begin
            p   = sx * sy;
            res = p;
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Issue one operation, scramble inputs afterwards, wait (bounded) for done.
    task automatic run_op(input logic op, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cnt);
        start       = 1'b1;
        div_or_mult = op;
        a           = x;
        b           = y;
        @(posedge clock);
        #1;
        start       = 1'b0;
        a           = $urandom;
        b           = $urandom;
        div_or_mult = 1'($urandom_range(0, 1));
        busy_cnt    = busy ? 1 : 0;
        lat         = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        div_or_mult = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mult_directed();
        int lat;
        int bc;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 32", bc); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
        @(posedge clock);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bc);
        n_checks++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
        n_checks++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_div_directed();
        int lat;
        int bc;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow_lo: got %h expected 80000000", lo); end
        n_checks++; if (hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_overflow_hi: got %h expected 00000000", hi); end
    endtask

    task automatic test_div_zero();
        int lat;
        int bc;
        // 0x451 / 0x20 = 0x22 remainder 0x11 presets hi/lo.
        run_op(1'b1, 32'h451, 32'h20, lat, bc);
        n_checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL div_zero_preset: got %h_%h expected 00000011_00000022", hi, lo); end
        run_op(1'b1, 32'd5, 32'd0, lat, bc);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div_zero_latency: got %0d expected 1", lat); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL div_zero_busy: got %0d busy cycles expected 0", bc); end
        n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL div_zero_flag: got %b expected 1", div_zero); end
        n_checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL div_zero_hold: got %h_%h expected 00000011_00000022", hi, lo); end
        @(posedge clock);
        #1;
        n_checks++; if ({done, div_zero} !== 2'b00) begin n_fail++; $display("FAIL div_zero_pulse: got done=%b div_zero=%b expected 0 0", done, div_zero); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        int          lat;
        x   = $urandom;
        y   = $urandom;
        exp = model(1'b0, x, y);
        start       = 1'b1;
        div_or_mult = 1'b0;
        a           = x;
        b           = y;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start       = 1'b1;
                div_or_mult = 1'b1;
                a           = ~x;
                b           = 32'd3;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_latency: got %0d expected 33", lat); end
        n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL ignore_start_result: a=%h b=%h got %h_%h expected %h", x, y, hi, lo, exp); end
    endtask

    task automatic test_random();
        logic        op;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        int          lat;
        int          bc;
        for (int i = 0; i < 24; i++) begin
            op = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       x = 32'($signed($urandom_range(0, 40)) - 20);
                1:       x = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       y = 32'($signed($urandom_range(0, 16)) - 8);
                default: y = $urandom;
            endcase
            if (y == 32'd0) y = 32'd1;
            exp_q.push_back(model(op, x, y));
            run_op(op, x, y, lat, bc);
            exp = exp_q.pop_front();
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL random_latency: op=%b got %0d expected 33", op, lat); end
            n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL random_result: op=%b a=%h b=%h got %h_%h expected %h", op, x, y, hi, lo, exp); end
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        int          bc;
        int          done_seen;
        logic [63:0] exp;
        run_op(1'b0, 32'd3, 32'd5, lat, bc);
        start       = 1'b1;
        div_or_mult = 1'b1;
        a           = 32'd1000;
        b           = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL abort_clear: got %h_%h expected 0_0", hi, lo); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen); end
        exp = model(1'b1, 32'hFFFF_FC18, 32'd7);
        run_op(1'b1, 32'hFFFF_FC18, 32'd7, lat, bc);
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 33", lat); end
        n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL abort_restart_result: got %h_%h expected %h", hi, lo, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        int          lat;
        int          bc;
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom | 32'd1;
            exp_q.push_back(model(i[0], x, y));
            run_op(i[0], x, y, lat, bc);
            exp = exp_q.pop_front();
            n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: op %0d got %0d expected 33", i, lat); end
            n_checks++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL b2b_result: op %0d a=%h b=%h got %h_%h expected %h", i, x, y, hi, lo, exp); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_ignore_start();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
